// File: rtl/bus_pkg.sv
// System bus types shared by every master, slave and the interconnect.
// Requests flow master->slave as m2s_s, responses flow back as s2m_s.
package bus;

    localparam int WORD_SIZE = 32;
    localparam int BUS_SEL_W = 4;

    typedef struct packed {
        logic [WORD_SIZE-3:0] addr;   // word address
        logic [WORD_SIZE-1:0] data;
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [BUS_SEL_W-1:0] sel;
    } m2s_s;

    typedef struct packed {
        logic [WORD_SIZE-1:0] data;
        logic                 ack;
        logic                 err;
        logic                 stall;
    } s2m_s;

    // Response driven by an idle or freshly reset slave.
    localparam s2m_s s2m_idle = '{data: '0, ack: 1'b0, err: 1'b0, stall: 1'b0};

endpackage

// File: rtl/bus_slave_ram_pkg.sv
// Local types for the bus RAM responder: FSM encoding and wait counter width.
package bus_slave_ram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Wide enough for WAIT_STATES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/bus_slave_ram_sram.sv
// Single-port word RAM with per-byte write enables and registered read.
// No reset on the array or the read register so it maps onto block RAM.
module sram_bytewe #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes and read-before-write registered read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_slave_ram.sv
// Pipelined wishbone RAM responder. Every accepted request is answered by
// exactly one ack (or err) on the following cycle.
// Optional build macro: BUS_SLAVE_RAM_RANGE_CHECK_EN - requests outside
// [BASE_ADDR, BASE_ADDR+DEPTH) get err and touch no RAM; without it the
// index simply wraps modulo DEPTH.
//
// Handshake: a request is valid while cyc & stb are high; the slave is ready
// when stall is low. A transfer happens on a clock edge where valid & ~stall,
// and the master must hold the request stable while stall is high.
module bus_slave_ram
    import bus::*;
    import bus_slave_ram_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int BASE_ADDR   = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  m2s_s   bus_slave_in_i,
    output s2m_s   bus_slave_out_o,
    output state_e state_dbg
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [31:0]    BASE_W   = 32'(BASE_ADDR);
    localparam logic [31:0]    DEPTH_W  = 32'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             stall_c;
    logic             accept;
    logic             resp_ok;
    logic             borrow;
    logic [31:0]      off;
    logic [AW-1:0]    index;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic             ack_q;
    logic             err_q;
    logic             rd_sel_q;
    logic [31:0]      data_q;
    logic [31:0]      data_out;

    assign req = bus_slave_in_i.cyc & bus_slave_in_i.stb;

    // Offset from the window base; borrow flags addresses below the base.
    assign {borrow, off} = {1'b0, 2'b00, bus_slave_in_i.addr} - {1'b0, BASE_W};
    assign index         = off[AW-1:0];

`ifdef BUS_SLAVE_RAM_RANGE_CHECK_EN
    assign resp_ok = ~borrow & (off < DEPTH_W);
`else
    logic unused_range;
    assign unused_range = ^{borrow, off[31:AW]};
    assign resp_ok      = 1'b1;
`endif

    // Stall is combinational so a new request is held off in the same cycle.
    always_comb begin
        stall_c = 1'b0;
        if (WAIT_STATES != 0 && !rst) begin
            case (state)
                ST_IDLE: stall_c = req;
                ST_WAIT: stall_c = bus_slave_in_i.cyc & (cnt != '0);
                default: stall_c = 1'b0;
            endcase
        end
    end

    assign accept = req & ~stall_c;

    // Wait-state sequencer: count down N-1..0, abort when the master drops cyc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (WAIT_STATES != 0) begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (!bus_slave_in_i.cyc) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_we = (accept & resp_ok & bus_slave_in_i.we) ? bus_slave_in_i.sel : 4'b0000;

    sram_bytewe #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (index),
        .wdata (bus_slave_in_i.data),
        .rdata (ram_rdata)
    );

    // Read data comes straight from the RAM register for the cycle after a
    // read accept, otherwise the last presented value is held.
    assign data_out = rd_sel_q ? ram_rdata : data_q;

    // One-cycle response pulse and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            data_q   <= '0;
        end else begin
            ack_q    <= accept & resp_ok;
            err_q    <= accept & ~resp_ok;
            rd_sel_q <= accept & resp_ok & ~bus_slave_in_i.we;
            data_q   <= data_out;
        end
    end

    always_comb begin
        bus_slave_out_o       = s2m_idle;
        bus_slave_out_o.data  = data_out;
        bus_slave_out_o.ack   = ack_q & bus_slave_in_i.cyc;
        bus_slave_out_o.err   = err_q;
        bus_slave_out_o.stall = stall_c;
    end

    assign state_dbg = state;

endmodule

// File: doc/bus_slave_ram.md
Name: bus_slave_ram

Overview:
Pipelined wishbone responder (slave) presenting a word-addressed, byte-writable RAM on one slave port of the system bus interconnect. It consumes bus::m2s_s and returns bus::s2m_s. Every accepted request receives exactly one ack (or err) on the following cycle, which is the timing the interconnect's one-cycle response pipe requires. Optional wait states are inserted with stall.

Parameters:
DEPTH, 1024, RAM size in 32-bit words; power of two, >=2.
WAIT_STATES, 0, stall cycles inserted before each request is accepted; 0..15.
BASE_ADDR, 0, word address of RAM location 0; used for the index offset and the range check.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
bus_slave_in_i  in  bus::m2s_s  request from interconnect: addr (WORD_SIZE-2 word address), data, cyc, stb, we, sel[3:0].
bus_slave_out_o  out  bus::s2m_s  response: data, ack, err, stall.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: ack=0, err=0, stall=0, data=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- req = cyc & stb. accept = req & ~stall. Write effects and ack scheduling occur only on accept.
- index = (addr - BASE_ADDR), truncated to $clog2(DEPTH) bits.
- WAIT_STATES=0:
  - stall is tied 0 and the FSM stays in IDLE.
  - A request is accepted every cycle it is presented (full back-to-back pipelining).
- WAIT_STATES=N>0, FSM states IDLE and WAIT:
  - IDLE: if req, drive stall=1 combinationally, load cnt=N-1, go to WAIT.
  - WAIT: if cnt!=0, stall=1 and cnt decrements. If cnt==0, stall=0, the request is accepted, and the FSM returns to IDLE.
  - Each request therefore sees N stall cycles: presented at cycle t, accepted at t+N, ack at t+N+1.
  - cyc low in WAIT aborts to IDLE. No ack is issued and no write occurs.
- Accepted write: at the accept edge, byte lane k of the RAM word is updated with data[8k+7:8k] where sel[k]=1. Other lanes keep their value.
- Accepted read: at the accept edge, the data register loads RAM[index] with all 32 bits, regardless of sel. On writes the data register holds its value.
- Response: ack_q is set on the edge after accept and held for exactly one cycle. Output ack = ack_q & cyc, so a master that drops cyc gets no ack.
- Read-after-write to the same index on back-to-back accepts returns the newly written data, since the write commits one edge earlier.
- Write then read in one accept is impossible because each accept is a single transaction.
- Reset asserted mid-operation: all outputs return to reset values immediately. Pending acks are lost. A write on the same edge as reset assertion is not guaranteed.
- err is always 0 unless the optional feature is compiled in.

Optional Feature:
BUS_SLAVE_RAM_RANGE_CHECK_EN
- Defined:
  - An accepted request with (addr < BASE_ADDR) or (addr - BASE_ADDR >= DEPTH) performs no RAM access.
  - Such a request gets err=1 instead of ack one cycle later, with data unchanged.
  - Wait states still apply.
- Undefined: index wraps modulo DEPTH and every accepted request is acked.

Decomposition:
- Package bus: add constant bus::s2m_idle = {data 0, ack 0, err 0, stall 0}, used as the reset/idle response.
- Package bus: add BUS_SEL_W = 4.
- Sub-module sram_bytewe (params DEPTH; ports clk, we[3:0], addr, wdata, rdata): synchronous read, per-byte write enable, no reset. It is inferable as block RAM.
- bus_slave_ram holds the FSM, the counter, the ack/err register and the range check.

Test Plan:
1. WAIT_STATES=0: write addr 0x10, data 0xDEADBEEF, sel 0xF, then back-to-back read 0x10.
   -> stall=0 throughout; ack in the cycle after each accept; read data 0xDEADBEEF.
2. Byte lanes: with word 0x10 = 0xDEADBEEF, write data 0x11223344 with sel 0x5, then read.
   -> data 0xDE22BE44.
3. WAIT_STATES=3: read presented at cycle 0.
   -> stall=1 in cycles 0-2; accept at cycle 3; ack=1 at cycle 4 only.
   -> Next request presented at cycle 4 is accepted at cycle 7.
4. WAIT_STATES=3: drop cyc at cycle 1 of a write to 0x20.
   -> No ack in any later cycle; word 0x20 unchanged; FSM back in IDLE.
5. Assert rst asynchronously mid-cycle while ack_q=1.
   -> ack, stall and data read 0 before the next clk edge.
   -> A read after reset deassertion is acked normally.
6. With BUS_SLAVE_RAM_RANGE_CHECK_EN, DEPTH=1024, BASE_ADDR=0x400: write to addr 0x800.
   -> err=1 for one cycle, ack=0; word 0 unchanged.
   -> Without the macro: ack=1 and word 0 is written.
